brent_kung_pipe_adder: RTL



---
 rtl/brent_kung_pipe_adder.sv | 118 +++++++++++
 1 files changed

// File: rtl/brent_kung_pipe_adder.sv
// Fully pipelined Brent-Kung prefix adder with valid/ready on both sides.
// Optional subtract mode is built when the macro BK_SUB_EN is defined.
module brent_kung_pipe_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             cin,
`ifdef BK_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LOG2W   = $clog2(WIDTH);
  localparam int LATENCY = 2 * LOG2W;
  // Banks holding prefix state; the last register bank is the sum/cout output.
  localparam int NumMid  = LATENCY - 1;

  if ((WIDTH < 4) || (WIDTH > 64) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("brent_kung_pipe_adder: WIDTH must be a power of two in 4..64");
  end

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;

  logic [WIDTH-1:0] p_q   [NumMid];
  logic [WIDTH-1:0] g_q   [NumMid];
  logic [WIDTH-1:0] gp_q  [NumMid];
  logic [WIDTH-1:0] g_nx  [NumMid];
  logic [WIDTH-1:0] gp_nx [NumMid];
  logic [NumMid-1:0]  cin_q;
  logic [LATENCY-1:0] valid_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;

`ifdef BK_SUB_EN
  assign b_eff   = sub ? ~data2 : data2;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = data2;
  assign cin_eff = cin;
`endif

  // Carry-in is treated as a generate at bit -1 and absorbed into bit 0.
  assign p_in = data1 ^ b_eff;
  assign g_in = (data1 & b_eff) | {{(WIDTH - 1){1'b0}}, p_in[0] & cin_eff};

  // Level j operates on bank j: up-sweep black cells first, then down-sweep grey cells.
  for (genvar j = 0; j < NumMid; j++) begin : g_level
    localparam bit Down = (j + 1) > LOG2W;
    localparam int K    = Down ? (2 * LOG2W - 2 - j) : j;
    localparam int Half = 1 << K;
    localparam int Span = 2 * Half;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (Down ? ((((i + 1) % Span) == Half) && (i >= Span + Half - 1))
               : (((i + 1) % Span) == 0)) begin : g_cell
        assign g_nx[j][i]  = g_q[j][i] | (gp_q[j][i] & g_q[j][i-Half]);
        assign gp_nx[j][i] = gp_q[j][i] & gp_q[j][i-Half];
      end else begin : g_pass
        assign g_nx[j][i]  = g_q[j][i];
        assign gp_nx[j][i] = gp_q[j][i];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign sum       = sum_q;
  assign cout      = cout_q;

  // Data banks only load on valid beats so the output holds across bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      cin_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      for (int s = 0; s < NumMid; s++) begin
        p_q[s]  <= '0;
        g_q[s]  <= '0;
        gp_q[s] <= '0;
      end
    end else if (!stall) begin
      valid_q <= {valid_q[LATENCY-2:0], in_valid};
      if (in_valid) begin
        p_q[0]   <= p_in;
        g_q[0]   <= g_in;
        gp_q[0]  <= p_in;
        cin_q[0] <= cin_eff;
      end
      for (int s = 1; s < NumMid; s++) begin
        if (valid_q[s-1]) begin
          p_q[s]   <= p_q[s-1];
          g_q[s]   <= g_nx[s-1];
          gp_q[s]  <= gp_nx[s-1];
          cin_q[s] <= cin_q[s-1];
        end
      end
      if (valid_q[NumMid-1]) begin
        sum_q  <= p_q[NumMid-1] ^ {g_nx[NumMid-1][WIDTH-2:0], cin_q[NumMid-1]};
        cout_q <= g_nx[NumMid-1][WIDTH-1];
      end
    end
  end

endmodule
